// File: rtl/afe_pkg.sv
// Shared types and helpers for the AFE injection scan controller.
package afe_pkg;

  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } afe_state_e;

  // Increment val by one when en is set, sticking at max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val,
                                          input logic        en);
    logic [31:0] res;
    res = val;
    if (en && (val < max_val)) res = val + 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/afe_sync.sv
// Multi-flop synchroniser for the asynchronous comparator output.
// SYNC_ST must be at least 2.
module afe_sync #(
  parameter int SYNC_ST = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_ST-1:0] sync_d;
  logic [SYNC_ST-1:0] sync_q;

  // Shift the raw input one stage further down the chain each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_ST-2:0], d_in};
  end

  // Synchroniser flops, cleared on reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q_out = sync_q[SYNC_ST-1];

endmodule

// File: rtl/afe_inj_scan_ctrl.sv
// Charge-injection burst sequencer with per-slot hit and time-over-threshold
// measurement on the comparator.
// Optional feature macro: AFE_TOT_SUM_EN adds the TOT accumulator output tot_sum.
//
// state | meaning
// IDLE  | waiting for start
// PULSE | inj high, width counter running
// GAP   | inj low, remainder of the slot period running
// FIN   | burst complete, done pulses on exit
module afe_inj_scan_ctrl
  import afe_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int SYNC_ST = 2
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] n_inj,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] width,
  input  logic          comp,
  output logic          inj,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] hit_cnt,
  output logic [CW-1:0] tot,
`ifdef AFE_TOT_SUM_EN
  output logic [2*CW-1:0] tot_sum,
`endif
  output logic          tot_vld
);

  localparam logic [31:0] SAT_MAX = (32'd1 << CW) - 32'd1;

  afe_state_e    state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [CW-1:0] slot_d, slot_q;
  logic [CW-1:0] we_d, we_q;
  logic [CW-1:0] gap_d, gap_q;
  logic [CW-1:0] tot_cnt_d, tot_cnt_q;
  logic [CW-1:0] hit_cnt_d, hit_cnt_q;
  logic [CW-1:0] tot_d, tot_q;
  logic          hit_flag_d, hit_flag_q;
  logic          comp_prev_d, comp_prev_q;
  logic          inj_d, inj_q, busy_d, busy_q, done_d, done_q, tot_vld_d, tot_vld_q;
`ifdef AFE_TOT_SUM_EN
  logic [2*CW-1:0] tot_sum_d, tot_sum_q;
`endif

  logic          comp_s;
  logic [CW-1:0] we_in, gap_in;
  logic [CW:0]   pe_in;
  logic [CW-1:0] tot_cnt_nx;
  logic          in_win, hit_now;

  afe_sync #(.SYNC_ST(SYNC_ST)) u_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .d_in  (comp),
    .q_out (comp_s)
  );

  // Effective width is at least 1; period is stretched to leave at least one low cycle.
  assign we_in  = (width == '0) ? CW'(1) : width;
  assign pe_in  = ({1'b0, period} > {1'b0, we_in}) ? {1'b0, period} : ({1'b0, we_in} + 1'b1);
  assign gap_in = CW'(pe_in - {1'b0, we_in});

  // Next-state, slot timing and measurement logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    we_d        = we_q;
    gap_d       = gap_q;
    tot_cnt_d   = tot_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    tot_d       = tot_q;
    hit_flag_d  = hit_flag_q;
    comp_prev_d = comp_s;
    inj_d       = inj_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tot_vld_d   = 1'b0;
`ifdef AFE_TOT_SUM_EN
    tot_sum_d   = tot_sum_q;
`endif

    in_win     = (state_q == PULSE) || (state_q == GAP);
    tot_cnt_nx = CW'(sat_inc(32'(tot_cnt_q), SAT_MAX, comp_s));
    hit_now    = hit_flag_q | (comp_s & ~comp_prev_q);

    if (in_win) begin
      tot_cnt_d  = tot_cnt_nx;
      hit_flag_d = hit_now;
    end

    if (abort) begin
      state_d    = IDLE;
      inj_d      = 1'b0;
      busy_d     = 1'b0;
      tot_cnt_d  = '0;
      hit_flag_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            we_d       = we_in;
            gap_d      = gap_in;
            slot_d     = n_inj;
            hit_cnt_d  = '0;
            tot_d      = '0;
            tot_cnt_d  = '0;
            hit_flag_d = 1'b0;
            busy_d     = 1'b1;
`ifdef AFE_TOT_SUM_EN
            tot_sum_d  = '0;
`endif
            if (n_inj == '0) begin
              state_d = FIN;
            end else begin
              state_d = PULSE;
              inj_d   = 1'b1;
              cnt_d   = we_in - CW'(1);
            end
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            inj_d   = 1'b0;
            cnt_d   = gap_q - CW'(1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            tot_d      = tot_cnt_nx;
            tot_vld_d  = 1'b1;
            hit_cnt_d  = CW'(sat_inc(32'(hit_cnt_q), SAT_MAX, hit_now));
            tot_cnt_d  = '0;
            hit_flag_d = 1'b0;
`ifdef AFE_TOT_SUM_EN
            tot_sum_d  = tot_sum_q + (2*CW)'(tot_cnt_nx);
`endif
            if (slot_q == CW'(1)) begin
              state_d = FIN;
            end else begin
              slot_d  = slot_q - CW'(1);
              state_d = PULSE;
              inj_d   = 1'b1;
              cnt_d   = we_q - CW'(1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        FIN: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      we_q        <= '0;
      gap_q       <= '0;
      tot_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      tot_q       <= '0;
      hit_flag_q  <= 1'b0;
      comp_prev_q <= 1'b0;
      inj_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tot_vld_q   <= 1'b0;
`ifdef AFE_TOT_SUM_EN
      tot_sum_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      we_q        <= we_d;
      gap_q       <= gap_d;
      tot_cnt_q   <= tot_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      tot_q       <= tot_d;
      hit_flag_q  <= hit_flag_d;
      comp_prev_q <= comp_prev_d;
      inj_q       <= inj_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tot_vld_q   <= tot_vld_d;
`ifdef AFE_TOT_SUM_EN
      tot_sum_q   <= tot_sum_d;
`endif
    end
  end

  assign inj     = inj_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign hit_cnt = hit_cnt_q;
  assign tot     = tot_q;
  assign tot_vld = tot_vld_q;
`ifdef AFE_TOT_SUM_EN
  assign tot_sum = tot_sum_q;
`endif

endmodule

// File: tb/tb_afe_inj_scan_ctrl.sv
// Directed bench for afe_inj_scan_ctrl.
module tb_afe_inj_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] n_inj = 8'd0;
  logic [7:0] period = 8'd0;
  logic [7:0] width = 8'd0;
  logic       comp = 1'b0;
  logic       inj, busy, done, tot_vld;
  logic [7:0] hit_cnt, tot;
`ifdef AFE_TOT_SUM_EN
  logic [15:0] tot_sum;
`endif

  int checks = 0;
  int failures = 0;

  bit         inj_tr [0:599];
  bit         busy_tr[0:599];
  bit         done_tr[0:599];
  bit         vld_tr [0:599];
  logic [7:0] tot_tr [0:599];

  afe_inj_scan_ctrl #(.CW(8), .SYNC_ST(2)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .start   (start),
    .abort   (abort),
    .n_inj   (n_inj),
    .period  (period),
    .width   (width),
    .comp    (comp),
    .inj     (inj),
    .busy    (busy),
    .done    (done),
    .hit_cnt (hit_cnt),
    .tot     (tot),
`ifdef AFE_TOT_SUM_EN
    .tot_sum (tot_sum),
`endif
    .tot_vld (tot_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts a burst with the current cfg and records outputs for ncyc cycles.
  // Trace index c is sampled at the negedge after the c-th posedge following start accept.
  // mode 0: comp low; mode 1: comp high for 5 cycles starting 1 cycle after each inj rise;
  // mode 2: comp high from the start cycle onward.
  task automatic capture(input int ncyc, input int mode, input int abort_at, input int restart_at);
    int last_rise;
    bit prev_inj;
    last_rise = -100;
    prev_inj  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    comp  = (mode == 2);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      inj_tr[c]  = inj;
      busy_tr[c] = busy;
      done_tr[c] = done;
      vld_tr[c]  = tot_vld;
      tot_tr[c]  = tot;
      start = (c == restart_at);
      abort = (c == abort_at);
      if (c == restart_at) begin
        n_inj = 8'd9; period = 8'd2; width = 8'd1;
      end
      if (mode == 1) begin
        if (inj && !prev_inj) last_rise = c;
        comp = (c >= last_rise + 1) && (c <= last_rise + 5);
      end
      prev_inj = inj;
    end
    start = 1'b0;
    abort = 1'b0;
    comp  = 1'b0;
  endtask

  task automatic test_reset_state();
    checks++;
    if ({inj, busy, done, tot_vld, hit_cnt, tot} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {inj, busy, done, tot_vld, hit_cnt, tot});
    end
  endtask

  task automatic test_reset();
    n_inj = 8'd3; period = 8'd10; width = 8'd4;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c < 12) comp = (c >= 1) && (c <= 5);
    end
    checks++;
    if ({inj, busy, hit_cnt, tot} !== {1'b1, 1'b1, 8'd1, 8'd5}) begin
      failures++;
      $display("FAIL pre_reset got inj=%b busy=%b hit=%0d tot=%0d exp 1 1 1 5", inj, busy, hit_cnt, tot);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({inj, busy, done, tot_vld, hit_cnt, tot} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {inj, busy, done, tot_vld, hit_cnt, tot});
    end
    comp = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    idle(4);
  endtask

  task automatic test_burst_quiet();
    n_inj = 8'd3; period = 8'd10; width = 8'd4;
    capture(36, 0, -1, -1);
    for (int c = 0; c < 36; c++) begin
      checks++;
      if (inj_tr[c] !== ((c < 30) && ((c % 10) < 4))) begin
        failures++; $display("FAIL quiet_inj c=%0d got=%b", c, inj_tr[c]);
      end
      checks++;
      if (done_tr[c] !== (c == 31)) begin
        failures++; $display("FAIL quiet_done c=%0d got=%b", c, done_tr[c]);
      end
      checks++;
      if (busy_tr[c] !== (c <= 30)) begin
        failures++; $display("FAIL quiet_busy c=%0d got=%b", c, busy_tr[c]);
      end
      checks++;
      if (vld_tr[c] !== ((c > 0) && (c <= 30) && ((c % 10) == 0))) begin
        failures++; $display("FAIL quiet_vld c=%0d got=%b", c, vld_tr[c]);
      end
      if ((c > 0) && (c <= 30) && ((c % 10) == 0)) begin
        checks++;
        if (tot_tr[c] !== 8'd0) begin
          failures++; $display("FAIL quiet_tot c=%0d got=%0d exp=0", c, tot_tr[c]);
        end
      end
    end
    checks++;
    if (hit_cnt !== 8'd0) begin
      failures++; $display("FAIL quiet_hit got=%0d exp=0", hit_cnt);
    end
    idle(3);
  endtask

  task automatic test_burst_hits();
    n_inj = 8'd3; period = 8'd10; width = 8'd4;
    capture(36, 1, -1, 5);
    for (int c = 0; c < 36; c++) begin
      checks++;
      if (inj_tr[c] !== ((c < 30) && ((c % 10) < 4))) begin
        failures++; $display("FAIL hits_inj c=%0d got=%b", c, inj_tr[c]);
      end
      checks++;
      if (done_tr[c] !== (c == 31)) begin
        failures++; $display("FAIL hits_done c=%0d got=%b", c, done_tr[c]);
      end
      if ((c > 0) && (c <= 30) && ((c % 10) == 0)) begin
        checks++;
        if ({vld_tr[c], tot_tr[c]} !== {1'b1, 8'd5}) begin
          failures++; $display("FAIL hits_tot c=%0d got vld=%b tot=%0d exp 1 5", c, vld_tr[c], tot_tr[c]);
        end
      end
    end
    checks++;
    if (hit_cnt !== 8'd3) begin
      failures++; $display("FAIL hits_cnt got=%0d exp=3", hit_cnt);
    end
    idle(3);
  endtask

  task automatic test_edge_cfg();
    n_inj = 8'd0; period = 8'd10; width = 8'd4;
    capture(6, 0, -1, -1);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({inj_tr[c], vld_tr[c], done_tr[c], busy_tr[c]} !== {1'b0, 1'b0, (c == 1), (c == 0)}) begin
        failures++;
        $display("FAIL zero_inj c=%0d got inj=%b vld=%b done=%b busy=%b", c, inj_tr[c], vld_tr[c], done_tr[c], busy_tr[c]);
      end
    end
    checks++;
    if ({hit_cnt, tot} !== 16'h0) begin
      failures++; $display("FAIL zero_inj_clear got hit=%0d tot=%0d exp 0 0", hit_cnt, tot);
    end
    idle(2);
    n_inj = 8'd3; period = 8'd0; width = 8'd0;
    capture(10, 0, -1, -1);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (inj_tr[c] !== ((c < 6) && ((c % 2) == 0))) begin
        failures++; $display("FAIL min_width_inj c=%0d got=%b", c, inj_tr[c]);
      end
      checks++;
      if ({done_tr[c], vld_tr[c]} !== {(c == 7), ((c == 2) || (c == 4) || (c == 6))}) begin
        failures++; $display("FAIL min_width_flags c=%0d got done=%b vld=%b", c, done_tr[c], vld_tr[c]);
      end
    end
    idle(2);
  endtask

  task automatic test_saturation();
    n_inj = 8'd2; period = 8'd255; width = 8'd4;
    capture(515, 2, -1, -1);
    checks++;
    if ({vld_tr[255], tot_tr[255]} !== {1'b1, 8'd254}) begin
      failures++; $display("FAIL sat_slot1 got vld=%b tot=%0d exp 1 254", vld_tr[255], tot_tr[255]);
    end
    checks++;
    if ({vld_tr[510], tot_tr[510]} !== {1'b1, 8'd255}) begin
      failures++; $display("FAIL sat_slot2 got vld=%b tot=%0d exp 1 255", vld_tr[510], tot_tr[510]);
    end
    checks++;
    if (done_tr[511] !== 1'b1) begin
      failures++; $display("FAIL sat_done got=%b exp=1", done_tr[511]);
    end
    checks++;
    if ({hit_cnt, tot} !== {8'd1, 8'd255}) begin
      failures++; $display("FAIL sat_final got hit=%0d tot=%0d exp 1 255", hit_cnt, tot);
    end
    idle(4);
  endtask

  task automatic test_abort();
    int vld_n;
    int done_n;
    n_inj = 8'd4; period = 8'd10; width = 8'd4;
    capture(20, 1, 11, -1);
    checks++;
    if ({inj_tr[11], inj_tr[12], busy_tr[11], busy_tr[12]} !== 4'b1010) begin
      failures++;
      $display("FAIL abort_cut got inj11=%b inj12=%b busy11=%b busy12=%b exp 1 0 1 0", inj_tr[11], inj_tr[12], busy_tr[11], busy_tr[12]);
    end
    vld_n = 0;
    done_n = 0;
    for (int c = 12; c < 20; c++) begin
      checks++;
      if (inj_tr[c] !== 1'b0) begin
        failures++; $display("FAIL abort_inj c=%0d got=%b exp=0", c, inj_tr[c]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      vld_n += int'(vld_tr[c]);
      done_n += int'(done_tr[c]);
    end
    checks++;
    if ({vld_n, done_n} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL abort_pulses got vld=%0d done=%0d exp 1 0", vld_n, done_n);
    end
    checks++;
    if ({hit_cnt, tot} !== {8'd1, 8'd5}) begin
      failures++; $display("FAIL abort_hold got hit=%0d tot=%0d exp 1 5", hit_cnt, tot);
    end
    idle(2);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({inj, busy, done, hit_cnt} !== {3'b000, 8'd1}) begin
        failures++;
        $display("FAIL start_abort c=%0d got inj=%b busy=%b done=%b hit=%0d exp 0 0 0 1", c, inj, busy, done, hit_cnt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    idle(3);
    test_reset_state();
    rst_b = 1'b1;
    idle(2);
    test_reset();
    test_burst_quiet();
    test_burst_hits();
    test_edge_cfg();
    test_saturation();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
